// File: rtl/arith_pkg.sv
// Shared encodings and helpers for the integer root datapath.
package arith_pkg;

    localparam logic MODE_SQRT = 1'b0;
    localparam logic MODE_CBRT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT    = 3'd1,
        ST_MUL_WAIT = 3'd2,
        ST_CMP      = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // Number of root digits produced for a radicand of the given width.
    function automatic int root_digits(input int width, input int m);
        return (width + m - 1) / m;
    endfunction

endpackage

// File: rtl/seq_mul.sv
// Shift-add unsigned multiplier: one multiplier bit per cycle, RW cycles total.
// Bit 0 is folded in on the start edge so the product and done pulse land
// exactly RW edges after start.
module seq_mul #(
    parameter int RW = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [RW-1:0]     a,
    input  logic [RW-1:0]     b,
    output logic [2*RW-1:0]   p,
    output logic              done
);

    localparam int CW = $clog2(RW + 1);

    logic              running;
    logic [CW-1:0]     cnt;
    logic [2*RW-1:0]   mcand;
    logic [RW-1:0]     mplier;

    // Load operands on start, then accumulate one partial product per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            p       <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!running) begin
                if (start) begin
                    running <= 1'b1;
                    cnt     <= CW'(RW - 1);
                    mcand   <= {{(RW-1){1'b0}}, a, 1'b0};
                    mplier  <= b >> 1;
                    p       <= b[0] ? {{RW{1'b0}}, a} : '0;
                end
            end else begin
                if (mplier[0]) begin
                    p <= p + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/int_root.sv
// Digit-by-digit floor square / cube root with remainder.
//
// state       | meaning
// ST_IDLE     | waiting for start; ready may be high for one cycle here
// ST_SHIFT    | double y, form the square trial value or launch the cube product
// ST_MUL_WAIT | waiting for y*(y+1) from seq_mul (cube only)
// ST_CMP      | subtract trial value if it fits, advance or finish
// ST_DONE     | publish y/remainder, pulse ready
module int_root
    import arith_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int RW    = (WIDTH + 2) / 3 + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] x_in,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] r_out
);

    localparam int BW    = 2 * WIDTH;
    localparam int SW    = $clog2(BW);
    localparam int K_SQ  = root_digits(WIDTH, 2);
    localparam int K_CB  = root_digits(WIDTH, 3);
    localparam int S0_SQ = 2 * (K_SQ - 1);
    localparam int S0_CB = 3 * (K_CB - 1);

    state_t            state, state_nxt;
    logic              mode_q;
    logic [WIDTH-1:0]  x;
    logic [WIDTH-1:0]  y;
    logic [BW-1:0]     b;
    logic [SW-1:0]     s;

    logic [WIDTH-1:0]  y_dbl;
    logic [SW-1:0]     m_step;
    logic [RW-1:0]     mul_a;
    logic [RW-1:0]     mul_b;
    logic [2*RW-1:0]   mul_p;
    logic [BW-1:0]     p_ext;
    logic              mul_start;
    logic              mul_done;

    assign y_dbl  = {y[WIDTH-2:0], 1'b0};
    assign m_step = (mode_q == MODE_CBRT) ? SW'(3) : SW'(2);
    assign mul_a  = y_dbl[RW-1:0];
    assign mul_b  = mul_a + RW'(1);
    assign p_ext  = BW'(mul_p);

    seq_mul #(.RW(RW)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (mul_a),
        .b     (mul_b),
        .p     (mul_p),
        .done  (mul_done)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and multiplier launch.
    always_comb begin
        state_nxt = state;
        mul_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (mode_q == MODE_CBRT) begin
                    mul_start = 1'b1;
                    state_nxt = ST_MUL_WAIT;
                end else begin
                    state_nxt = ST_CMP;
                end
            end
            ST_MUL_WAIT: begin
                if (mul_done) begin
                    state_nxt = ST_CMP;
                end
            end
            ST_CMP: begin
                state_nxt = (s >= m_step) ? ST_SHIFT : ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_SQRT;
            x      <= '0;
            y      <= '0;
            b      <= '0;
            s      <= '0;
            busy   <= 1'b0;
            ready  <= 1'b0;
            y_out  <= '0;
            r_out  <= '0;
        end else begin
            ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        x      <= x_in;
                        y      <= '0;
                        b      <= '0;
                        mode_q <= mode;
                        s      <= (mode == MODE_CBRT) ? SW'(S0_CB) : SW'(S0_SQ);
                        busy   <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    y <= y_dbl;
                    if (mode_q == MODE_SQRT) begin
                        b <= ((BW'(y_dbl) << 1) | BW'(1)) << s;
                    end
                end
                ST_MUL_WAIT: begin
                    if (mul_done) begin
                        b <= (((p_ext << 1) + p_ext) + BW'(1)) << s;
                    end
                end
                ST_CMP: begin
                    if (BW'(x) >= b) begin
                        x <= x - b[WIDTH-1:0];
                        y <= y + WIDTH'(1);
                    end
                    if (s >= m_step) begin
                        s <= s - m_step;
                    end
                end
                ST_DONE: begin
                    y_out <= y;
                    r_out <= x;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_root.sv
// Self-checking bench for int_root: directed corner cases plus random
// operations compared against a brute-force root model.
module tb_int_root;

    localparam int WIDTH = 16;
    localparam int RW    = (WIDTH + 2) / 3 + 1;

    logic             clk   = 1'b0;
    logic             rst   = 1'b0;
    logic             start = 1'b0;
    logic             mode  = 1'b0;
    logic [WIDTH-1:0] x_in  = '0;
    logic             busy;
    logic             ready;
    logic [WIDTH-1:0] y_out;
    logic [WIDTH-1:0] r_out;

    int checks = 0;
    int errors = 0;

    int_root #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .x_in  (x_in),
        .busy  (busy),
        .ready (ready),
        .y_out (y_out),
        .r_out (r_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned ipow(input longint unsigned v, input int m);
        return (m == 1) ? v * v * v : v * v;
    endfunction

    // Largest y with y^M <= x, by plain search.
    function automatic longint unsigned ref_root(input int m, input longint unsigned v);
        longint unsigned r = 0;
        while (ipow(r + 1, m) <= v) r++;
        return r;
    endfunction

    function automatic int lat(input int m);
        int mm = (m == 1) ? 3 : 2;
        int k  = (WIDTH + mm - 1) / mm;
        int c  = (m == 1) ? 2 + RW : 2;
        return k * c + 1;
    endfunction

    task automatic run_op(input int m, input logic [WIDTH-1:0] x, input bit inj);
        int              n;
        int              lim;
        int              rcount;
        bit              busy_ok;
        longint unsigned ey;
        longint unsigned er;
        lim = lat(m);
        ey  = ref_root(m, x);
        er  = longint'(x) - ipow(ey, m);
        @(negedge clk);
        start = 1'b1;
        mode  = m[0];
        x_in  = x;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = 1'($urandom);
        x_in  = WIDTH'($urandom);
        chk("accept_busy", busy, 1);
        chk("accept_ready_low", ready, 0);
        n = 0;
        busy_ok = 1'b1;
        while (n < lim + 20) begin
            @(posedge clk);
            #1;
            n++;
            start = inj && (n == 4 || n == 9);
            if (ready) break;
            if (!busy) busy_ok = 1'b0;
        end
        start = 1'b0;
        chk("latency", n, lim);
        chk("y_out", y_out, ey);
        chk("r_out", r_out, er);
        chk("busy_held", busy_ok, 1);
        chk("busy_drop", busy, 0);
        if (inj) begin
            rcount = 0;
            for (int i = 0; i < lim; i++) begin
                @(posedge clk);
                #1;
                if (ready) rcount++;
            end
            chk("extra_ready", rcount, 0);
            chk("hold_y", y_out, ey);
            chk("hold_r", r_out, er);
        end
    endtask

    initial begin
        int rcount;
        int m;
        int r;
        logic [WIDTH-1:0] x;

        #2;
        rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ready", ready, 0);
        chk("rst_y", y_out, 0);
        chk("rst_r", r_out, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op(0, 16'd100, 0);
        run_op(0, 16'd65535, 0);
        run_op(1, 16'd27, 0);
        run_op(1, 16'd1000, 1);
        run_op(1, 16'd65535, 0);
        run_op(0, 16'd0, 0);
        run_op(1, 16'd0, 0);
        run_op(0, 16'd1, 0);
        run_op(1, 16'd7, 0);

        for (int i = 0; i < 40; i++) begin
            m = int'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: x = WIDTH'($urandom);
                1: begin
                    r = (m == 1) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 255));
                    x = WIDTH'(ipow(longint'(r), m));
                end
                default: begin
                    r = (m == 1) ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 255));
                    x = WIDTH'(ipow(longint'(r), m) - 1);
                end
            endcase
            run_op(m, x, (i % 10) == 3);
        end

        // Abort a cube operation with reset mid-flight.
        run_op(0, 16'd100, 0);
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b1;
        x_in  = 16'hFFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_ready", ready, 0);
        chk("abort_y", y_out, 0);
        chk("abort_r", r_out, 0);
        rcount = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (ready) rcount++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (ready) rcount++;
        end
        chk("abort_no_ready", rcount, 0);
        chk("abort_idle_busy", busy, 0);
        run_op(0, 16'd49, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
